// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 3-sample mid-bit majority
// voting, false-start rejection, and framing/parity/break reporting.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (8..65535)
//   DATA_BITS     data bits per character (5..9)
//   PARITY        0 = none, 1 = even, 2 = odd
//   STOP_BITS     1 or 2
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       synchronous reset, active low
//   i_rxd         asynchronous serial line, idles high
//   o_data        received character, LSB = first bit on the wire
//   o_data_valid  one-cycle pulse; o_data and flags valid in this cycle
//   o_frame_err   a stop bit was sampled low
//   o_parity_err  parity mismatch (always 0 when PARITY = 0)
//   o_break       data, parity and first stop bit all sampled low
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 422,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_data_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_break
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned H  = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(H);
  localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
  localparam logic [3:0]    IDX_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rxs;
  logic [CW-1:0]        cnt;
  logic [3:0]           idx;
  logic                 s0;
  logic                 s1;
  logic [DATA_BITS-1:0] sh;
  logic                 par_err;
  logic                 brk_ok;
  logic                 first_stop_low;

  logic vote;
  logic dec;
  logic wrap;
  logic cur_first_low;
  logic fe_now;
  logic brk_now;

  always_comb begin
    // Third sample is the live rxs on the decision cycle itself.
    vote = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    dec  = (cnt == CNT_DEC);
    wrap = (cnt == CNT_LAST);
    // On the first stop bit the live vote is the first-stop value; on the
    // second one the value recorded earlier is used.
    cur_first_low = (idx == 4'd0) ? ~vote : first_stop_low;
    fe_now        = cur_first_low | ~vote;
    brk_now       = brk_ok & cur_first_low;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= S_IDLE;
      rx_meta        <= 1'b1;
      rxs            <= 1'b1;
      cnt            <= '0;
      idx            <= '0;
      s0             <= 1'b1;
      s1             <= 1'b1;
      sh             <= '0;
      par_err        <= 1'b0;
      brk_ok         <= 1'b0;
      first_stop_low <= 1'b0;
      o_data         <= '0;
      o_data_valid   <= 1'b0;
      o_frame_err    <= 1'b0;
      o_parity_err   <= 1'b0;
      o_break        <= 1'b0;
    end else begin
      rx_meta <= i_rxd;
      rxs     <= rx_meta;

      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_break      <= 1'b0;

      if (state == S_IDLE || state == S_WAIT_IDLE || wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (cnt == CNT_S0) s0 <= rxs;
      if (cnt == CNT_S1) s1 <= rxs;

      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state          <= S_START;
            brk_ok         <= 1'b1;
            par_err        <= 1'b0;
            first_stop_low <= 1'b0;
          end
        end

        S_START: begin
          if (dec && vote) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (wrap) begin
            state <= S_DATA;
            idx   <= '0;
          end
        end

        S_DATA: begin
          if (dec) begin
            sh     <= {vote, sh[DATA_BITS-1:1]};
            brk_ok <= brk_ok & ~vote;
          end
          if (wrap) begin
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end

        S_PARITY: begin
          if (dec) begin
            if (PARITY == 2) begin
              par_err <= ~(^sh ^ vote);
            end else begin
              par_err <= ^sh ^ vote;
            end
            brk_ok <= brk_ok & ~vote;
          end
          if (wrap) begin
            state <= S_STOP;
            idx   <= '0;
          end
        end

        S_STOP: begin
          if (dec) begin
            if (idx == STOP_LAST) begin
              // Character completes mid-stop-bit so a following start edge
              // is never missed.
              o_data       <= sh;
              o_data_valid <= 1'b1;
              o_frame_err  <= fe_now;
              o_parity_err <= par_err;
              o_break      <= brk_now;
              state        <= fe_now ? S_WAIT_IDLE : S_IDLE;
              cnt          <= '0;
              idx          <= '0;
            end else begin
              first_stop_low <= ~vote;
            end
          end else if (wrap) begin
            idx <= idx + 4'd1;
          end
        end

        S_WAIT_IDLE: begin
          if (rxs) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;
  localparam int N = 16;
  localparam int H = N / 2;
  localparam int LAT_8N1 = 4 + N * 9 + H;
  localparam int LAT_8E1 = 4 + N * 10 + H;
  localparam int LAT_7N2 = 4 + N * 9 + H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic rxd_a, rxd_b, rxd_c;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic valid_a, fe_a, pe_a, brk_a;
  logic valid_b, fe_b, pe_b, brk_b;
  logic valid_c, fe_c, pe_c, brk_c;

  uart_rx_param #(.CLKS_PER_BIT(N), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_rxd(rxd_a), .o_data(data_a), .o_data_valid(valid_a),
    .o_frame_err(fe_a), .o_parity_err(pe_a), .o_break(brk_a));
  uart_rx_param #(.CLKS_PER_BIT(N), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_b), .i_rxd(rxd_b), .o_data(data_b), .o_data_valid(valid_b),
    .o_frame_err(fe_b), .o_parity_err(pe_b), .o_break(brk_b));
  uart_rx_param #(.CLKS_PER_BIT(N), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_c (
    .i_clk(clk), .i_rst_n(rst_c), .i_rxd(rxd_c), .o_data(data_c), .o_data_valid(valid_c),
    .o_frame_err(fe_c), .o_parity_err(pe_c), .o_break(brk_c));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int flag_viol = 0;

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
    logic       brk;
    int         cyc;
  } rec_t;

  rec_t q_a[$];
  rec_t q_b[$];
  rec_t q_c[$];

  always @(negedge clk) begin
    rec_t r;
    r.cyc = cyc;
    if (valid_a) begin
      r.data = {1'b0, data_a}; r.fe = fe_a; r.pe = pe_a; r.brk = brk_a; q_a.push_back(r);
    end else if (fe_a | pe_a | brk_a) flag_viol++;
    if (valid_b) begin
      r.data = {1'b0, data_b}; r.fe = fe_b; r.pe = pe_b; r.brk = brk_b; q_b.push_back(r);
    end else if (fe_b | pe_b | brk_b) flag_viol++;
    if (valid_c) begin
      r.data = {2'b0, data_c}; r.fe = fe_c; r.pe = pe_c; r.brk = brk_c; q_c.push_back(r);
    end else if (fe_c | pe_c | brk_c) flag_viol++;
  end

  // Reference: decode a wire frame (bit 0 = start bit) from the protocol rules.
  function automatic rec_t model(input logic [15:0] fr, input int d, input int p, input int s);
    rec_t e;
    logic pb;
    int   pn;
    e.data = '0;
    for (int i = 0; i < d; i++) e.data[i] = fr[1 + i];
    pn = (p != 0) ? 1 : 0;
    pb = (p != 0) ? fr[1 + d] : 1'b0;
    if (p == 0)      e.pe = 1'b0;
    else if (p == 1) e.pe = ^e.data ^ pb;
    else             e.pe = ~(^e.data ^ pb);
    e.fe = 1'b0;
    for (int i = 0; i < s; i++) if (fr[1 + d + pn + i] == 1'b0) e.fe = 1'b1;
    e.brk = (e.data == 9'd0) && (pb == 1'b0) && (fr[1 + d + pn] == 1'b0);
    e.cyc = 0;
    return e;
  endfunction

  function automatic int qsize(input int w);
    case (w)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic set_rx(input int w, input logic v);
    case (w)
      0:       rxd_a = v;
      1:       rxd_b = v;
      default: rxd_c = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int w, input logic [15:0] fr, input int nb);
    for (int i = 0; i < nb; i++) begin
      set_rx(w, fr[i]);
      idle(N);
    end
  endtask

  task automatic wait_n(input int w, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (qsize(w) >= n) break;
      @(posedge clk);
    end
    idle(2 * N);
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
    @(posedge clk); #1;
    idle(3);
    checks++;
    if ({data_a, valid_a, fe_a, pe_a, brk_a} !== 12'h000) begin
      errors++; $display("FAIL reset_a: got %h expected 000", {data_a, valid_a, fe_a, pe_a, brk_a});
    end
    checks++;
    if ({data_b, valid_b, fe_b, pe_b, brk_b} !== 12'h000) begin
      errors++; $display("FAIL reset_b: got %h expected 000", {data_b, valid_b, fe_b, pe_b, brk_b});
    end
    checks++;
    if ({data_c, valid_c, fe_c, pe_c, brk_c} !== 11'h000) begin
      errors++; $display("FAIL reset_c: got %h expected 000", {data_c, valid_c, fe_c, pe_c, brk_c});
    end
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    idle(2 * N);
  endtask

  task automatic test_back_to_back();
    logic [15:0] f0, f1;
    rec_t e0, e1;
    int t0;
    q_a.delete();
    f0 = 16'({1'b1, 8'hA5, 1'b0});
    f1 = 16'({1'b1, 8'h3C, 1'b0});
    e0 = model(f0, 8, 0, 1);
    e1 = model(f1, 8, 0, 1);
    t0 = cyc;
    send(0, f0, 10);
    send(0, f1, 10);
    wait_n(0, 2, 400);
    checks++;
    if (q_a.size() !== 2) begin
      errors++; $display("FAIL b2b_count: got %0d expected 2", q_a.size());
    end
    if (q_a.size() >= 2) begin
      checks++;
      if ({q_a[0].data, q_a[0].fe, q_a[0].pe, q_a[0].brk} !== {e0.data, e0.fe, e0.pe, e0.brk}) begin
        errors++; $display("FAIL b2b_first: got %h expected %h",
          {q_a[0].data, q_a[0].fe, q_a[0].pe, q_a[0].brk}, {e0.data, e0.fe, e0.pe, e0.brk});
      end
      checks++;
      if ({q_a[1].data, q_a[1].fe, q_a[1].pe, q_a[1].brk} !== {e1.data, e1.fe, e1.pe, e1.brk}) begin
        errors++; $display("FAIL b2b_second: got %h expected %h",
          {q_a[1].data, q_a[1].fe, q_a[1].pe, q_a[1].brk}, {e1.data, e1.fe, e1.pe, e1.brk});
      end
      checks++;
      if (q_a[0].cyc - t0 < LAT_8N1 - 1 || q_a[0].cyc - t0 > LAT_8N1 + 1) begin
        errors++; $display("FAIL b2b_latency: got %0d expected %0d", q_a[0].cyc - t0, LAT_8N1);
      end
      checks++;
      if (q_a[1].cyc - q_a[0].cyc < 159 || q_a[1].cyc - q_a[0].cyc > 161) begin
        errors++; $display("FAIL b2b_spacing: got %0d expected 160", q_a[1].cyc - q_a[0].cyc);
      end
    end
  endtask

  task automatic test_random_8n1();
    rec_t ex[6];
    int   ts[6];
    logic [15:0] fr;
    q_a.delete();
    for (int i = 0; i < 6; i++) begin
      fr = 16'({1'b1, 8'($urandom_range(0, 255)), 1'b0});
      ex[i] = model(fr, 8, 0, 1);
      ts[i] = cyc;
      send(0, fr, 10);
      idle($urandom_range(0, 20));
    end
    wait_n(0, 6, 400);
    checks++;
    if (q_a.size() !== 6) begin
      errors++; $display("FAIL rand8n1_count: got %0d expected 6", q_a.size());
    end
    for (int i = 0; i < 6 && i < q_a.size(); i++) begin
      checks++;
      if ({q_a[i].data, q_a[i].fe, q_a[i].pe, q_a[i].brk} !== {ex[i].data, ex[i].fe, ex[i].pe, ex[i].brk}) begin
        errors++; $display("FAIL rand8n1_char%0d: got %h expected %h", i,
          {q_a[i].data, q_a[i].fe, q_a[i].pe, q_a[i].brk}, {ex[i].data, ex[i].fe, ex[i].pe, ex[i].brk});
      end
      checks++;
      if (q_a[i].cyc - ts[i] < LAT_8N1 - 1 || q_a[i].cyc - ts[i] > LAT_8N1 + 1) begin
        errors++; $display("FAIL rand8n1_lat%0d: got %0d expected %0d", i, q_a[i].cyc - ts[i], LAT_8N1);
      end
    end
  endtask

  task automatic test_parity();
    rec_t ex[6];
    logic [15:0] fr[6];
    int t0;
    q_b.delete();
    fr[0] = 16'({1'b1, 1'b1, 8'h07, 1'b0});
    fr[1] = 16'({1'b1, 1'b0, 8'h07, 1'b0});
    for (int i = 2; i < 6; i++)
      fr[i] = 16'({1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0});
    t0 = cyc;
    for (int i = 0; i < 6; i++) begin
      ex[i] = model(fr[i], 8, 1, 1);
      send(1, fr[i], 11);
    end
    wait_n(1, 6, 400);
    checks++;
    if (q_b.size() !== 6) begin
      errors++; $display("FAIL parity_count: got %0d expected 6", q_b.size());
    end
    if (q_b.size() > 0) begin
      checks++;
      if (q_b[0].cyc - t0 < LAT_8E1 - 1 || q_b[0].cyc - t0 > LAT_8E1 + 1) begin
        errors++; $display("FAIL parity_latency: got %0d expected %0d", q_b[0].cyc - t0, LAT_8E1);
      end
    end
    for (int i = 0; i < 6 && i < q_b.size(); i++) begin
      checks++;
      if ({q_b[i].data, q_b[i].fe, q_b[i].pe, q_b[i].brk} !== {ex[i].data, ex[i].fe, ex[i].pe, ex[i].brk}) begin
        errors++; $display("FAIL parity_char%0d: got %h expected %h", i,
          {q_b[i].data, q_b[i].fe, q_b[i].pe, q_b[i].brk}, {ex[i].data, ex[i].fe, ex[i].pe, ex[i].brk});
      end
    end
  endtask

  task automatic test_false_start();
    logic [15:0] fr;
    rec_t e;
    q_a.delete();
    set_rx(0, 1'b0); idle(1); set_rx(0, 1'b1); idle(3 * N);
    set_rx(0, 1'b0); idle(5); set_rx(0, 1'b1); idle(3 * N);
    checks++;
    if (q_a.size() !== 0) begin
      errors++; $display("FAIL false_start_pulses: got %0d expected 0", q_a.size());
    end
    fr = 16'({1'b1, 8'($urandom_range(0, 255)), 1'b0});
    e = model(fr, 8, 0, 1);
    send(0, fr, 10);
    wait_n(0, 1, 300);
    checks++;
    if (q_a.size() !== 1) begin
      errors++; $display("FAIL false_start_recover_count: got %0d expected 1", q_a.size());
    end else begin
      checks++;
      if ({q_a[0].data, q_a[0].fe, q_a[0].pe, q_a[0].brk} !== {e.data, e.fe, e.pe, e.brk}) begin
        errors++; $display("FAIL false_start_recover: got %h expected %h",
          {q_a[0].data, q_a[0].fe, q_a[0].pe, q_a[0].brk}, {e.data, e.fe, e.pe, e.brk});
      end
    end
  endtask

  task automatic test_break();
    rec_t e;
    logic [15:0] fr;
    q_a.delete();
    e = model(16'h0000, 8, 0, 1);
    set_rx(0, 1'b0);
    idle(30 * N);
    set_rx(0, 1'b1);
    idle(5 * N);
    checks++;
    if (q_a.size() !== 1) begin
      errors++; $display("FAIL break_count: got %0d expected 1", q_a.size());
    end
    if (q_a.size() > 0) begin
      checks++;
      if ({q_a[0].data, q_a[0].fe, q_a[0].pe, q_a[0].brk} !== {e.data, e.fe, e.pe, e.brk}) begin
        errors++; $display("FAIL break_flags: got %h expected %h",
          {q_a[0].data, q_a[0].fe, q_a[0].pe, q_a[0].brk}, {e.data, e.fe, e.pe, e.brk});
      end
    end
    idle(10 * N);
    checks++;
    if (q_a.size() !== 1) begin
      errors++; $display("FAIL break_no_retrigger: got %0d expected 1", q_a.size());
    end
    fr = 16'({1'b1, 8'h5A, 1'b0});
    e = model(fr, 8, 0, 1);
    send(0, fr, 10);
    wait_n(0, 2, 300);
    checks++;
    if (q_a.size() !== 2) begin
      errors++; $display("FAIL break_after_count: got %0d expected 2", q_a.size());
    end else begin
      checks++;
      if ({q_a[1].data, q_a[1].fe, q_a[1].pe, q_a[1].brk} !== {e.data, e.fe, e.pe, e.brk}) begin
        errors++; $display("FAIL break_after: got %h expected %h",
          {q_a[1].data, q_a[1].fe, q_a[1].pe, q_a[1].brk}, {e.data, e.fe, e.pe, e.brk});
      end
    end
  endtask

  task automatic test_glitch();
    rec_t e;
    q_a.delete();
    e = model(16'({1'b1, 8'h00, 1'b0}), 8, 0, 1);
    send(0, 16'h0000, 4);
    // Data bit 3: one-cycle high pulse timed to land on the cnt = H sample.
    set_rx(0, 1'b0); idle(H + 1);
    set_rx(0, 1'b1); idle(1);
    set_rx(0, 1'b0); idle(N - H - 2);
    send(0, 16'b1_0000, 5);
    wait_n(0, 1, 300);
    checks++;
    if (q_a.size() !== 1) begin
      errors++; $display("FAIL glitch_count: got %0d expected 1", q_a.size());
    end else begin
      checks++;
      if ({q_a[0].data, q_a[0].fe, q_a[0].pe, q_a[0].brk} !== {e.data, e.fe, e.pe, e.brk}) begin
        errors++; $display("FAIL glitch_char: got %h expected %h",
          {q_a[0].data, q_a[0].fe, q_a[0].pe, q_a[0].brk}, {e.data, e.fe, e.pe, e.brk});
      end
    end
  endtask

  task automatic test_two_stop();
    rec_t ex[3];
    logic [15:0] fr[3];
    int t0, n0;
    q_c.delete();
    fr[0] = 16'({1'b0, 1'b1, 7'h55, 1'b0});
    fr[1] = 16'({1'b1, 1'b1, 7'($urandom_range(1, 127)), 1'b0});
    fr[2] = 16'({1'b1, 1'b1, 7'($urandom_range(1, 127)), 1'b0});
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      ex[i] = model(fr[i], 7, 0, 2);
      send(2, fr[i], 10);
      set_rx(2, 1'b1);
      idle(N);
    end
    wait_n(2, 3, 400);
    checks++;
    if (q_c.size() !== 3) begin
      errors++; $display("FAIL twostop_count: got %0d expected 3", q_c.size());
    end
    if (q_c.size() > 0) begin
      checks++;
      if (q_c[0].cyc - t0 < LAT_7N2 - 1 || q_c[0].cyc - t0 > LAT_7N2 + 1) begin
        errors++; $display("FAIL twostop_latency: got %0d expected %0d", q_c[0].cyc - t0, LAT_7N2);
      end
    end
    for (int i = 0; i < 3 && i < q_c.size(); i++) begin
      checks++;
      if ({q_c[i].data, q_c[i].fe, q_c[i].pe, q_c[i].brk} !== {ex[i].data, ex[i].fe, ex[i].pe, ex[i].brk}) begin
        errors++; $display("FAIL twostop_char%0d: got %h expected %h", i,
          {q_c[i].data, q_c[i].fe, q_c[i].pe, q_c[i].brk}, {ex[i].data, ex[i].fe, ex[i].pe, ex[i].brk});
      end
    end
    // Abandon a character mid-flight with reset.
    n0 = q_c.size();
    send(2, 16'({1'b1, 1'b1, 7'h2A, 1'b0}), 5);
    rst_c = 1'b0;
    set_rx(2, 1'b1);
    idle(1);
    checks++;
    if ({data_c, valid_c, fe_c, pe_c, brk_c} !== 11'h000) begin
      errors++; $display("FAIL midreset_outputs: got %h expected 000", {data_c, valid_c, fe_c, pe_c, brk_c});
    end
    idle(1);
    rst_c = 1'b1;
    idle(12 * N);
    checks++;
    if (q_c.size() !== n0) begin
      errors++; $display("FAIL midreset_pulses: got %0d expected %0d", q_c.size(), n0);
    end
  endtask

  task automatic test_flags_idle();
    checks++;
    if (flag_viol !== 0) begin
      errors++; $display("FAIL flags_without_valid: got %0d expected 0", flag_viol);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_random_8n1();
    test_parity();
    test_false_start();
    test_break();
    test_glitch();
    test_two_stop();
    test_flags_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver and successor to the fixed 8N1 receiver. Adds the following over that block:
- configurable data width, parity and stop bits
- 3-sample majority voting at mid-bit
- false-start rejection
- framing, parity and break reporting

Sits between the pad-side serial input and the command/byte-stream logic. Emits one pulse per received character.

Parameters:
CLKS_PER_BIT, 422, clock cycles per bit period; legal range 8..65535.
DATA_BITS, 8, number of data bits; legal range 5..9.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
i_clk  input  1  system clock; all logic on rising edge.
i_rst_n  input  1  synchronous reset, active low.
i_rxd  input  1  asynchronous serial line; idles high.
o_data  output  DATA_BITS  received character, LSB = first bit on the wire.
o_data_valid  output  1  one-cycle pulse; o_data and the flags are valid in this cycle.
o_frame_err  output  1  a stop bit was sampled low; qualified by o_data_valid.
o_parity_err  output  1  parity mismatch; always 0 when PARITY = 0; qualified by o_data_valid.
o_break  output  1  break condition: all data bits, the parity bit if present, and the first stop bit sampled low; qualified by o_data_valid.

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - state = IDLE.
  - Synchroniser flops = 1; bit counter and cycle counter = 0.
  - o_data = 0; o_data_valid, o_frame_err, o_parity_err, o_break = 0.
- Reset mid-character abandons the character and produces no pulse.
- Input sync: 2-flop synchroniser, reset value 1. All logic uses only the synchronised bit rxs, which lags i_rxd by 2 cycles.
- Cycle counter cnt:
  - Runs 0..CLKS_PER_BIT-1 in every state except IDLE and WAIT_IDLE, then wraps to 0.
  - Held at 0 in IDLE and WAIT_IDLE.
  - Width = clog2(CLKS_PER_BIT).
- Mid-bit sampling:
  - H = CLKS_PER_BIT/2 (integer division).
  - rxs is sampled at cnt = H-1, H and H+1.
  - The bit value is the majority of the 3 samples, decided on the cycle cnt = H+1.
- State machine:
  - IDLE: rxs = 0 -> START, with cnt = 0 on the next cycle.
  - START:
    - If the voted bit is 1 -> IDLE (false start; no pulse, no flags).
    - Otherwise continue; at cnt wrap -> DATA with bit index = 0.
  - DATA:
    - At each decision, the voted bit is stored at o_data-shift position [index]; shift in LSB first.
    - At wrap with index = DATA_BITS-1 -> PARITY if PARITY != 0, else STOP.
  - PARITY:
    - Voted bit p.
    - even: parity error if XOR(data, p) = 1.
    - odd: parity error if XOR(data, p) = 0.
    - At wrap -> STOP.
  - STOP:
    - Each stop bit is voted at its decision point.
    - With STOP_BITS = 2, the decision is made at the second stop bit and frame_err = either stop bit sampled low.
    - In the final decision cycle:
      - o_data updates.
      - o_data_valid pulses for the next cycle only, with the flags.
    - Next state (no wait for the end of the stop bit):
      - frame_err = 0 -> IDLE.
      - frame_err = 1 -> WAIT_IDLE.
  - WAIT_IDLE: stay until rxs = 1, then -> IDLE. This prevents a held-low line (break) from retriggering.
- o_data holds its value between pulses. The flags are zero whenever o_data_valid = 0.
- Break: o_break = 1 implies o_frame_err = 1. o_data = 0 during a break pulse.
- Latency: o_data_valid rises (2 + CLKS_PER_BIT*(1+DATA_BITS+PB+STOP_BITS-1) + H + 2) cycles after the i_rxd start edge, where PB = 1 if PARITY != 0 else 0. Verification checks this to within ±1 cycle.
- Back-to-back characters with 1 stop bit are received without loss, because the receiver re-enters IDLE mid-stop-bit.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0xA5 then 0x3C back-to-back -> two pulses, o_data = 0xA5 then 0x3C, all flags 0, pulses 160 ±1 cycles apart.
- PARITY=1 (even), send 0x07 with parity bit 1, then 0x07 with parity bit 0 -> first pulse has o_parity_err = 0; second pulse has o_parity_err = 1 and o_data = 0x07.
- 1-cycle glitch on the start bit, plus a 5-cycle low pulse (< H) on an idle line -> no o_data_valid; state returns to IDLE.
- Line held low for 30 bit times, then released -> exactly one pulse with o_break = 1, o_frame_err = 1, o_data = 0x00. No further pulse until a new start edge after release.
- 1-cycle high glitch inside data bit 3 of 0x00, at cnt = H -> majority rejects it; o_data = 0x00, no flags.
- DATA_BITS=7, STOP_BITS=2, second stop bit driven low for 0x55 -> o_data = 0x55, o_frame_err = 1. Then assert i_rst_n = 0 mid-character -> all outputs 0 next cycle, no pulse.
